// File: rtl/marker_select_if.sv
// ---------------------------------------------------------------------------
// marker_select_if
// Bundles the pixel/mouse/readback signals of marker_select.
//   master : drives frame_clk, DrawX/DrawY, mousex/mousey, click, clear, rd_idx;
//            observes is_cursor, is_marker, marker_idx, num_points, full,
//            rd_x/rd_y, rd_valid
//   slave  : the marker_select side (mirror of master)
// ---------------------------------------------------------------------------
interface marker_select_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  mousex;
    logic [9:0]  mousey;
    logic        click;
    logic        clear;
    logic [3:0]  rd_idx;

    logic        is_cursor;
    logic        is_marker;
    logic [3:0]  marker_idx;
    logic [4:0]  num_points;
    logic        full;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic        rd_valid;

    modport master (
        output frame_clk, DrawX, DrawY, mousex, mousey, click, clear, rd_idx,
        input  is_cursor, is_marker, marker_idx, num_points, full,
               rd_x, rd_y, rd_valid
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, mousex, mousey, click, clear, rd_idx,
        output is_cursor, is_marker, marker_idx, num_points, full,
               rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/marker_select.sv
// ---------------------------------------------------------------------------
// marker_select
// Mouse-driven selection of up to NUM_POINTS tracking points with cursor and
// marker overlay rendering and registered readback of stored points.
//
// Ports:
//   Clk    in   system clock, all state on posedge
//   Reset  in   synchronous, active-high
//   bus    slave modport of marker_select_if
//            frame_clk         frame strobe, edge-detected internally
//            DrawX/DrawY       pixel being drawn
//            mousex/mousey     raw mouse position (clamped on load)
//            click             left button level, rising edge captures
//            clear             level, drops all stored points
//            rd_idx            slot to read back (1-cycle latency)
//            is_cursor         pixel on cursor disc
//            is_marker         pixel on a stored point's square outline
//            marker_idx        lowest hitting slot, 0 when no hit
//            num_points/full   stored point count / count == NUM_POINTS
//            rd_x/rd_y/rd_valid registered contents of slot rd_idx
//
// State table:
//   S_EMPTY     | no points stored
//   S_SELECTING | some but not all points stored
//   S_FULL      | NUM_POINTS points stored, further captures rejected
// ---------------------------------------------------------------------------
module marker_select #(
    parameter int         NUM_POINTS  = 4,
    parameter logic [9:0] CURSOR_SIZE = 10'd4,
    parameter logic [9:0] MARKER_SIZE = 10'd3,
    parameter logic [9:0] X_MAX       = 10'd639,
    parameter logic [9:0] Y_MAX       = 10'd479
) (
    input  logic           Clk,
    input  logic           Reset,
    marker_select_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_SELECTING,
        S_FULL
    } state_t;

    localparam logic [22:0] CURSOR_R_SQ = 23'(CURSOR_SIZE) * 23'(CURSOR_SIZE);
    localparam logic [4:0]  NUM_P5      = 5'(NUM_POINTS);

    state_t      state_q, state_d;

    logic        frame_d, frame_rise;
    logic        click_d, click_rise;
    logic [9:0]  cur_x, cur_y;
    logic [9:0]  mouse_x_clamped, mouse_y_clamped;

    // Slot storage is sized for the maximum of 16; slots at or above
    // NUM_POINTS are never written and their valid bits stay 0.
    logic [9:0]  slot_x [16];
    logic [9:0]  slot_y [16];
    logic [15:0] slot_v;
    logic [4:0]  cnt_q;

    logic [3:0]  wr_idx, last_idx;
    logic        is_dup, is_full, accept, rd_in_range;

    assign mouse_x_clamped = (bus.mousex > X_MAX) ? X_MAX : bus.mousex;
    assign mouse_y_clamped = (bus.mousey > Y_MAX) ? Y_MAX : bus.mousey;

    // ---------------- capture qualification ----------------
    assign wr_idx   = cnt_q[3:0];
    assign last_idx = cnt_q[3:0] - 4'd1;
    assign is_dup   = (cnt_q != 5'd0) &&
                      (slot_x[last_idx] == cur_x) &&
                      (slot_y[last_idx] == cur_y);
    assign is_full  = (state_q == S_FULL);
    // clear outranks a coincident click edge
    assign accept   = click_rise && !bus.clear && !is_full && !is_dup;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = ((cnt_q + 5'd1) == NUM_P5) ? S_FULL : S_SELECTING;
        end
    end

    // ---------------- edge detect, cursor, count, readback ----------------
    assign rd_in_range = ({1'b0, bus.rd_idx} < NUM_P5);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_d    <= 1'b0;
            frame_rise <= 1'b0;
            click_d    <= 1'b0;
            click_rise <= 1'b0;
            cur_x      <= mouse_x_clamped;
            cur_y      <= mouse_y_clamped;
            cnt_q      <= 5'd0;
            slot_v     <= '0;
            bus.rd_x     <= 10'd0;
            bus.rd_y     <= 10'd0;
            bus.rd_valid <= 1'b0;
        end else begin
            frame_d    <= bus.frame_clk;
            frame_rise <= bus.frame_clk & ~frame_d;
            click_d    <= bus.click;
            click_rise <= bus.click & ~click_d;

            if (frame_rise) begin
                cur_x <= mouse_x_clamped;
                cur_y <= mouse_y_clamped;
            end

            if (bus.clear) begin
                cnt_q  <= 5'd0;
                slot_v <= '0;
            end else if (accept) begin
                cnt_q          <= cnt_q + 5'd1;
                slot_v[wr_idx] <= 1'b1;
            end

            bus.rd_x     <= slot_x[bus.rd_idx];
            bus.rd_y     <= slot_y[bus.rd_idx];
            bus.rd_valid <= rd_in_range && slot_v[bus.rd_idx];
        end
    end

    // Coordinates need no reset; validity is tracked by slot_v. The cursor
    // captured here is the value before any coincident frame update.
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            slot_x[wr_idx] <= cur_x;
            slot_y[wr_idx] <= cur_y;
        end
    end

    // ---------------- cursor rendering ----------------
    logic signed [10:0] cdx, cdy;
    logic signed [21:0] cdx_sq, cdy_sq;
    logic [22:0]        cdist_sq;

    assign cdx      = $signed({1'b0, bus.DrawX}) - $signed({1'b0, cur_x});
    assign cdy      = $signed({1'b0, bus.DrawY}) - $signed({1'b0, cur_y});
    assign cdx_sq   = cdx * cdx;
    assign cdy_sq   = cdy * cdy;
    assign cdist_sq = {1'b0, cdx_sq} + {1'b0, cdy_sq};

    assign bus.is_cursor = (cdist_sq <= CURSOR_R_SQ);

    // ---------------- marker rendering ----------------
    // Absolute distances are formed by ordered subtraction so a point near
    // the screen edge never wraps onto the opposite side.
    logic       hit_any;
    logic [3:0] hit_idx;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = 4'd0;
        // scan downward so the lowest hitting index is the one left standing
        for (int i = NUM_POINTS - 1; i >= 0; i--) begin
            logic [9:0] adx;
            logic [9:0] ady;
            adx = (bus.DrawX >= slot_x[i]) ? (bus.DrawX - slot_x[i]) : (slot_x[i] - bus.DrawX);
            ady = (bus.DrawY >= slot_y[i]) ? (bus.DrawY - slot_y[i]) : (slot_y[i] - bus.DrawY);
            if (slot_v[i] && (adx <= MARKER_SIZE) && (ady <= MARKER_SIZE) &&
                ((adx == MARKER_SIZE) || (ady == MARKER_SIZE))) begin
                hit_any = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    assign bus.is_marker  = hit_any;
    assign bus.marker_idx = hit_idx;
    assign bus.num_points = cnt_q;
    assign bus.full       = is_full;

endmodule

// File: tb/tb_marker_select.sv
module tb_marker_select;

    localparam int NP    = 4;
    localparam int XMAX  = 639;
    localparam int YMAX  = 479;
    localparam int CR    = 4;
    localparam int MS    = 3;

    logic Clk = 1'b0;
    logic Reset;

    marker_select_if bus();

    marker_select dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];

    // reference model
    int m_cur_x, m_cur_y, m_cnt;
    int m_sx[16];
    int m_sy[16];

    localparam int SEL_CUR = 0, SEL_MRK = 1, SEL_IDX = 2, SEL_NUM = 3,
                   SEL_FULL = 4, SEL_RDX = 5, SEL_RDY = 6, SEL_RDV = 7;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            SEL_CUR:  return int'(bus.is_cursor);
            SEL_MRK:  return int'(bus.is_marker);
            SEL_IDX:  return int'(bus.marker_idx);
            SEL_NUM:  return int'(bus.num_points);
            SEL_FULL: return int'(bus.full);
            SEL_RDX:  return int'(bus.rd_x);
            SEL_RDY:  return int'(bus.rd_y);
            default:  return int'(bus.rd_valid);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, sample(e.sel), e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int exp_cursor(input int x, input int y);
        int dx, dy;
        dx = x - m_cur_x;
        dy = y - m_cur_y;
        return (dx * dx + dy * dy <= CR * CR) ? 1 : 0;
    endfunction

    // returns -1 for no hit, else lowest hitting slot
    function automatic int exp_marker(input int x, input int y);
        int ax, ay;
        for (int j = 0; j < m_cnt; j++) begin
            ax = iabs(x - m_sx[j]);
            ay = iabs(y - m_sy[j]);
            if (ax <= MS && ay <= MS && (ax == MS || ay == MS)) return j;
        end
        return -1;
    endfunction

    task automatic model_capture();
        if (m_cnt < NP &&
            !(m_cnt > 0 && m_sx[m_cnt-1] == m_cur_x && m_sy[m_cnt-1] == m_cur_y)) begin
            m_sx[m_cnt] = m_cur_x;
            m_sy[m_cnt] = m_cur_y;
            m_cnt++;
        end
    endtask

    task automatic do_frame(input int x, input int y);
        bus.mousex    = 10'(x);
        bus.mousey    = 10'(y);
        bus.frame_clk = 1'b1;
        tick(2);
        bus.frame_clk = 1'b0;
        tick(2);
        m_cur_x = clampv(x, XMAX);
        m_cur_y = clampv(y, YMAX);
    endtask

    task automatic do_click(input int hold);
        bus.click = 1'b1;
        tick(hold);
        bus.click = 1'b0;
        tick(3);
        model_capture();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(1);
        m_cnt = 0;
    endtask

    task automatic check_pixel(input string tag, input int x, input int y);
        int mi;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        mi = exp_marker(x, y);
        push({tag, "_cur"}, SEL_CUR, exp_cursor(x, y));
        push({tag, "_mrk"}, SEL_MRK, (mi >= 0) ? 1 : 0);
        push({tag, "_idx"}, SEL_IDX, (mi >= 0) ? mi : 0);
        drain();
    endtask

    task automatic check_status(input string tag);
        push({tag, "_num"},  SEL_NUM,  m_cnt);
        push({tag, "_full"}, SEL_FULL, (m_cnt == NP) ? 1 : 0);
        drain();
    endtask

    task automatic check_read(input string tag, input int idx);
        bool_t_dummy: begin end
        bus.rd_idx = 4'(idx);
        tick(1);
        if (idx < NP && idx < m_cnt) begin
            push({tag, "_rdx"}, SEL_RDX, m_sx[idx]);
            push({tag, "_rdy"}, SEL_RDY, m_sy[idx]);
            push({tag, "_rdv"}, SEL_RDV, 1);
        end else begin
            push({tag, "_rdv"}, SEL_RDV, 0);
        end
        drain();
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd0;
        bus.mousex    = 10'd50;
        bus.mousey    = 10'd60;
        bus.click     = 1'b0;
        bus.clear     = 1'b0;
        bus.rd_idx    = 4'd0;
        Reset         = 1'b1;
        m_cnt         = 0;
        m_cur_x       = 50;
        m_cur_y       = 60;

        // reset state, observed while Reset is held
        tick(3);
        check_status("rst");
        push("rst_rdx", SEL_RDX, 0);
        push("rst_rdy", SEL_RDY, 0);
        push("rst_rdv", SEL_RDV, 0);
        drain();
        check_pixel("rst_at_mouse", 50, 60);
        check_pixel("rst_off_disc", 50, 65);
        Reset = 1'b0;
        tick(1);

        // clamped cursor and disc edge
        do_frame(700, 500);
        check_pixel("clamp_in",   639, 475);
        check_pixel("clamp_out",  639, 474);
        check_pixel("clamp_left", 635, 479);
        check_pixel("clamp_far",  634, 479);

        // reset asserted while click_rise is high drops the capture
        bus.click = 1'b1;
        tick(1);
        Reset = 1'b1;
        tick(1);
        Reset     = 1'b0;
        bus.click = 1'b0;
        tick(3);
        check_status("rst_mid");
        check_pixel("rst_mid_px", 636, 479);
        check_read("rst_mid_rd", 0);

        // long click gives one capture
        do_frame(100, 100);
        do_click(50);
        check_status("hold");
        check_pixel("hold_edge", 103, 100);
        check_pixel("hold_in",   101, 100);
        check_pixel("hold_top",  100, 97);

        // duplicate rejection and readback
        do_clear();
        check_status("clr1");
        do_frame(200, 50);
        do_click(2);
        do_click(2);
        check_status("dup");
        check_read("dup_rd0", 0);
        check_read("dup_rd1", 1);
        check_read("rd_oor5", 5);
        check_read("rd_oor15", 15);

        // fill to capacity, then one more click
        do_frame(300, 200); do_click(2);
        do_frame(400, 300); do_click(2);
        do_frame(500, 400); do_click(2);
        check_status("fill");
        do_frame(10, 10);
        do_click(5);
        check_status("over");
        for (int k = 0; k < NP; k++) check_read($sformatf("over_rd%0d", k), k);
        check_pixel("over_px", 10, 13);
        check_pixel("over_s3", 497, 400);

        // overlapping outlines, lowest index wins
        do_clear();
        do_frame(50, 50); do_click(2);
        do_frame(52, 50); do_click(2);
        check_status("ovl");
        check_pixel("ovl_both", 53, 53);
        check_pixel("ovl_s1",   55, 50);

        // clear and click_rise in the same cycle
        do_frame(60, 60);
        bus.click = 1'b1;
        tick(1);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        bus.click = 1'b0;
        tick(3);
        m_cnt = 0;
        check_status("clrclk");
        check_pixel("clrclk_s0", 53, 50);
        check_pixel("clrclk_s1", 55, 50);
        check_pixel("clrclk_cur", 63, 60);
        check_read("clrclk_rd", 0);

        // frame and click edges coincide; point at origin must not wrap
        do_frame(0, 0);
        bus.mousex    = 10'd30;
        bus.mousey    = 10'd40;
        bus.frame_clk = 1'b1;
        bus.click     = 1'b1;
        tick(2);
        bus.frame_clk = 1'b0;
        bus.click     = 1'b0;
        tick(3);
        model_capture();
        m_cur_x = 30;
        m_cur_y = 40;
        check_status("coin");
        check_read("coin_rd", 0);
        check_pixel("wrap_x",  1023, 0);
        check_pixel("origin",  3, 2);
        check_pixel("newcur",  30, 40);
        check_pixel("oldcur",  0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/marker_select.md
MARKER_SELECT -- requirements
Module: marker_select

Interface
REQ-001 Parameter NUM_POINTS, default 4: number of selectable tracking points (1..16).
REQ-002 Parameter CURSOR_SIZE, default 10'd4: cursor disc radius in pixels.
REQ-003 Parameter MARKER_SIZE, default 10'd3: half-width of the hollow square drawn at each stored point.
REQ-004 Parameter X_MAX, default 10'd639: rightmost legal X coordinate.
REQ-005 Parameter Y_MAX, default 10'd479: bottommost legal Y coordinate.
REQ-006 Clk  input  1  50 MHz system clock; the block has one clock, and all state is updated on posedge Clk.
REQ-007 Reset  input  1  reset is synchronous and active-high.
REQ-008 frame_clk  input  1  frame strobe (~60 Hz), asynchronous to pixel position and edge-detected internally.
REQ-009 DrawX, DrawY  input  10 each  current pixel coordinates.
REQ-010 mousex, mousey  input  10 each  raw mouse coordinates.
REQ-011 click  input  1  mouse left button level; high while pressed.
REQ-012 clear  input  1  level; discards all stored points.
REQ-013 rd_idx  input  4  index of the stored point to read back.
REQ-014 is_cursor  output  1  current pixel lies on the cursor disc.
REQ-015 is_marker  output  1  current pixel lies on the outline of a valid stored point.
REQ-016 marker_idx  output  4  lowest index of the stored points that hit the current pixel; 0 when is_marker=0.
REQ-017 num_points  output  5  count of valid stored points.
REQ-018 full  output  1  high when num_points==NUM_POINTS.
REQ-019 rd_x, rd_y  output  10 each  registered coordinates of slot rd_idx.
REQ-020 rd_valid  output  1  registered valid bit of slot rd_idx; 0 if rd_idx>=NUM_POINTS.

Function
REQ-021 Frame edge: the block SHALL register frame_clk as frame_d and register frame_rise <= frame_clk & ~frame_d, giving a one-cycle pulse.
REQ-022 The cursor position SHALL update only in the cycle frame_rise=1, loading min(mousex,X_MAX) and min(mousey,Y_MAX); otherwise it holds.
REQ-023 Click edge: the block SHALL register click as click_d and register click_rise <= click & ~click_d; a held button yields exactly one pulse.
REQ-024 With click high sampled at edge k, click_rise SHALL be high after edge k, and the slot write and num_points increment SHALL occur at edge k+1.
REQ-025 A capture SHALL store the latched cursor position (not raw mousex/mousey) into slot[num_points] and set its valid bit.
REQ-026 Capture SHALL be rejected if full=1, or if num_points>0 and the latched cursor equals the last stored point (duplicate).
REQ-027 State machine EMPTY / SELECTING / FULL: EMPTY->SELECTING on an accepted capture while NUM_POINTS>1; EMPTY->FULL on an accepted capture when NUM_POINTS==1; SELECTING->FULL on the capture that makes the count NUM_POINTS; any state->EMPTY on clear.
REQ-028 clear SHALL zero num_points and all valid bits at the next edge; slot coordinates may retain stale data.
REQ-029 If clear and click_rise occur in the same cycle, clear SHALL win and the capture SHALL be dropped.
REQ-030 If frame_rise and click_rise coincide, the capture SHALL store the pre-update cursor position.
REQ-031 Cursor rendering SHALL be combinational: dx=DrawX-curX and dy=DrawY-curY as signed 11-bit values; is_cursor=1 iff dx*dx+dy*dy <= CURSOR_SIZE*CURSOR_SIZE, evaluated at 22-bit or wider precision with no overflow.
REQ-032 Marker rendering SHALL be combinational: for a valid slot i, a hit requires |dx_i|<=MARKER_SIZE, |dy_i|<=MARKER_SIZE, and (|dx_i|==MARKER_SIZE or |dy_i|==MARKER_SIZE); is_marker is the OR of all slot hits, and marker_idx is the lowest hitting index.
REQ-033 Readback SHALL have one-cycle latency: rd_x/rd_y/rd_valid reflect rd_idx sampled at the previous edge and slot contents as of that edge.
REQ-034 Coordinate arithmetic SHALL be free of wrap-around: a point at x=0 whose outline extends to negative X SHALL NOT draw at X=1023.

Reset
REQ-035 While Reset=1, the block SHALL set num_points=0, full=0, all valid bits 0, state EMPTY, frame_d/frame_rise/click_d/click_rise 0, rd_x=rd_y=0, rd_valid=0, and cursor=(min(mousex,X_MAX), min(mousey,Y_MAX)).
REQ-036 A Reset asserted mid-capture (click_rise=1) SHALL take priority, and no slot SHALL be written.

Verification
REQ-037 Mouse (700,500), one frame_rise -> cursor (639,479); pixel (639,475) gives is_cursor=1 and pixel (639,474) gives is_cursor=0.
REQ-038 Cursor (100,100), click held 50 cycles -> exactly one capture, num_points=1; pixel (103,100) gives is_marker=1 with marker_idx=0, and pixel (101,100) gives is_marker=0.
REQ-039 Four captures at distinct positions with NUM_POINTS=4 -> full=1 and state FULL; a fifth click leaves num_points=4 and slots unchanged.
REQ-040 Click twice at an unchanged cursor (200,50) -> num_points=1 (duplicate rejected); rd_idx=0 gives rd_x=200, rd_y=50, rd_valid=1 one cycle later.
REQ-041 clear and click_rise in the same cycle with num_points=2 -> num_points=0, is_marker=0 everywhere, state EMPTY.
REQ-042 Stored point (0,0), pixel (1023,0) -> is_marker=0; pixel (3,2) -> is_marker=1.
